// File: rtl/detect_edge_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : detect_edge_pkg
//  Purpose  : Shared types for the armed one-shot edge detector: the FSM
//             state encoding and a helper that picks the edge polarity.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package detect_edge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FIRING = 2'd2
  } state_t;

  // Rising = now high and previously low; falling is the mirror image.
  function automatic logic select_edge(input logic sync_val,
                                       input logic prev_val,
                                       input logic rising);
    return rising ? (sync_val & ~prev_val) : (~sync_val & prev_val);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : sync_chain
//  Purpose  : Multi-flop synchronizer bringing an asynchronous level into
//             the clk domain.
//  Ports    : clk - clock (rising edge)
//             rst - synchronous active-high reset, clears every stage
//             d   - asynchronous input level
//             q   - synchronized level, STAGES clocks behind d
//  Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Bit 0 is the metastability-catching flop; the level walks toward the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/detect_edge.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : detect_edge
//  Purpose  : Armed one-shot edge detector. Once armed, the first selected
//             edge of the synchronized target produces a TRIG_CYCLES-wide
//             trigger pulse, after which the detector disarms itself.
//  Ports    : clk     - clock (rising edge)
//             rst     - synchronous active-high reset
//             target  - monitored asynchronous signal
//             arm     - arm request, level-sampled each clock
//             trigger - registered one-shot pulse
//  Revision : 1.0 - initial release
// ============================================================================
module detect_edge #(
  parameter int TRIG_CYCLES = 1,
  parameter int RISING_EDGE = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic target,
  input  logic arm,
  output logic trigger
);

  import detect_edge_pkg::*;

  localparam int               CNT_W    = $clog2(TRIG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TRIG_CYCLES - 1);
  localparam logic             RISING   = (RISING_EDGE != 0);

  logic             w_sync;
  logic             r_prev;
  logic             w_edge;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_trigger;
  logic             w_trigger_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (target),
    .q   (w_sync)
  );

  assign w_edge = select_edge(w_sync, r_prev, RISING);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= 1'b0;
      r_state   <= IDLE;
      r_count   <= '0;
      r_trigger <= 1'b0;
    end else begin
      r_prev    <= w_sync;
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_trigger <= w_trigger_nxt;
    end
  end

  // Only the registered ARMED state can fire: an edge seen on the very clock
  // that arm is first sampled lands while still IDLE and is discarded.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_trigger_nxt = r_trigger;
    case (r_state)
      IDLE: begin
        w_trigger_nxt = 1'b0;
        if (arm) begin
          w_state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (w_edge) begin
          w_state_nxt   = FIRING;
          w_count_nxt   = CNT_LOAD;
          w_trigger_nxt = 1'b1;
        end
      end
      FIRING: begin
        // Counter holds the number of further high cycles still owed.
        if (r_count == '0) begin
          w_state_nxt   = IDLE;
          w_trigger_nxt = 1'b0;
        end else begin
          w_count_nxt   = r_count - CNT_W'(1);
          w_trigger_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_count_nxt   = '0;
        w_trigger_nxt = 1'b0;
      end
    endcase
  end

  assign trigger = r_trigger;

endmodule
`default_nettype wire

// File: tb/tb_detect_edge.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_detect_edge
//  Purpose  : Self-checking bench for detect_edge with three instances:
//             rising/1-cycle, rising/3-cycle and falling/1-cycle. Each step
//             word is {rst, arm[f1,r3,r1], target, expected trig[f1,r3,r1]};
//             inputs change after a falling clock edge and the trigger is
//             read at the following falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_detect_edge;

  import detect_edge_pkg::*;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       target = 1'b1;
  logic [2:0] arm    = 3'b000;
  logic [2:0] trig;

  int checks   = 0;
  int failures = 0;
  logic [2:0] sb [$];

  always #1 clk = ~clk;

  detect_edge #(.TRIG_CYCLES(1), .RISING_EDGE(1), .SYNC_STAGES(2)) u_r1 (
    .clk(clk), .rst(rst), .target(target), .arm(arm[0]), .trigger(trig[0]));
  detect_edge #(.TRIG_CYCLES(3), .RISING_EDGE(1), .SYNC_STAGES(2)) u_r3 (
    .clk(clk), .rst(rst), .target(target), .arm(arm[1]), .trigger(trig[1]));
  detect_edge #(.TRIG_CYCLES(1), .RISING_EDGE(0), .SYNC_STAGES(2)) u_f1 (
    .clk(clk), .rst(rst), .target(target), .arm(arm[2]), .trigger(trig[2]));

  task automatic test_reset();
    logic [7:0] seq [8];
    logic [2:0] exp_v;
    seq = '{8'b1_000_1_000, 8'b1_111_1_000, 8'b1_111_1_000,
            8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_000};
    for (int i = 0; i < 8; i++) begin
      {rst, arm, target} = seq[i][7:3];
      sb.push_back(seq[i][2:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (trig !== exp_v) begin
        failures++;
        $display("FAIL test_reset step %0d: trigger=%b expected=%b", i, trig, exp_v);
      end
      if (i == 2) begin
        checks++;
        if ({u_r1.u_sync.r_chain, u_r1.r_prev, u_f1.u_sync.r_chain, u_f1.r_prev} !== 6'b0) begin
          failures++;
          $display("FAIL test_reset sync_flops: got %b%b%b%b expected 000000",
                   u_r1.u_sync.r_chain, u_r1.r_prev, u_f1.u_sync.r_chain, u_f1.r_prev);
        end
        checks++;
        if (u_r3.r_state !== IDLE || u_r3.r_count !== 2'd0) begin
          failures++;
          $display("FAIL test_reset r3_state: state=%0d count=%0d expected 0/0",
                   u_r3.r_state, u_r3.r_count);
        end
      end
    end
    checks++;
    if (u_r1.r_state !== IDLE || u_r3.r_state !== IDLE || u_f1.r_state !== IDLE) begin
      failures++;
      $display("FAIL test_reset post_release_state: r1=%0d r3=%0d f1=%0d expected 0",
               u_r1.r_state, u_r3.r_state, u_f1.r_state);
    end
  endtask

  task automatic test_rise_wide();
    logic [7:0] seq [9];
    logic [2:0] exp_v;
    seq = '{8'b0_111_1_000, 8'b0_000_0_000, 8'b0_000_1_000,
            8'b0_000_1_100, 8'b0_000_1_011, 8'b0_000_1_010,
            8'b0_000_1_010, 8'b0_000_1_000, 8'b0_000_1_000};
    for (int i = 0; i < 9; i++) begin
      {rst, arm, target} = seq[i][7:3];
      sb.push_back(seq[i][2:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (trig !== exp_v) begin
        failures++;
        $display("FAIL test_rise_wide step %0d: trigger=%b expected=%b", i, trig, exp_v);
      end
    end
    checks++;
    if (u_r3.r_state !== IDLE) begin
      failures++;
      $display("FAIL test_rise_wide r3_idle: state=%0d expected 0", u_r3.r_state);
    end
  endtask

  task automatic test_fall();
    logic [7:0] seq [9];
    logic [2:0] exp_v;
    seq = '{8'b0_100_1_000, 8'b0_000_0_000, 8'b0_000_0_000,
            8'b0_000_0_100, 8'b0_000_1_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000};
    for (int i = 0; i < 9; i++) begin
      {rst, arm, target} = seq[i][7:3];
      sb.push_back(seq[i][2:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (trig !== exp_v) begin
        failures++;
        $display("FAIL test_fall step %0d: trigger=%b expected=%b", i, trig, exp_v);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] seq [23];
    logic [2:0] exp_v;
    seq = '{8'b0_000_1_000, 8'b0_000_0_000, 8'b0_000_0_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000,
            8'b0_111_1_000, 8'b0_000_0_000, 8'b0_000_0_000, 8'b0_000_1_100,
            8'b0_000_1_000, 8'b0_000_0_011, 8'b0_010_0_010, 8'b0_000_0_010,
            8'b0_000_0_000, 8'b0_000_0_000, 8'b0_000_0_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000};
    for (int i = 0; i < 23; i++) begin
      {rst, arm, target} = seq[i][7:3];
      sb.push_back(seq[i][2:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (trig !== exp_v) begin
        failures++;
        $display("FAIL test_one_shot step %0d: trigger=%b expected=%b", i, trig, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_fire();
    logic [7:0] seq [12];
    logic [2:0] exp_v;
    seq = '{8'b0_010_1_000, 8'b0_000_0_000, 8'b0_000_0_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_010, 8'b1_000_1_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000};
    for (int i = 0; i < 12; i++) begin
      {rst, arm, target} = seq[i][7:3];
      sb.push_back(seq[i][2:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (trig !== exp_v) begin
        failures++;
        $display("FAIL test_reset_mid_fire step %0d: trigger=%b expected=%b", i, trig, exp_v);
      end
    end
  endtask

  task automatic test_arm_coincident();
    logic [7:0] seq [22];
    logic [2:0] exp_v;
    seq = '{8'b0_000_1_000, 8'b0_000_0_000, 8'b0_000_0_000, 8'b0_100_0_000,
            8'b0_000_1_000, 8'b0_000_1_000, 8'b0_011_1_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_1_000, 8'b0_000_0_000,
            8'b0_000_0_000, 8'b0_000_0_100, 8'b0_000_0_000, 8'b0_000_1_000,
            8'b0_000_1_000, 8'b0_000_1_011, 8'b0_000_1_010, 8'b0_000_1_010,
            8'b0_000_1_000, 8'b0_000_1_000};
    for (int i = 0; i < 22; i++) begin
      {rst, arm, target} = seq[i][7:3];
      sb.push_back(seq[i][2:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (trig !== exp_v) begin
        failures++;
        $display("FAIL test_arm_coincident step %0d: trigger=%b expected=%b", i, trig, exp_v);
      end
    end
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_rise_wide();
    test_fall();
    test_one_shot();
    test_reset_mid_fire();
    test_arm_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/detect_edge.md
DETECT_EDGE -- requirements
Module: detect_edge

Interface
REQ-001 Parameter TRIG_CYCLES, default 1: number of clk cycles trigger stays high per firing; legal range 1..255.
REQ-002 Parameter RISING_EDGE, default 1: 1 = fire on target 0->1, 0 = fire on target 1->0.
REQ-003 Parameter SYNC_STAGES, default 2: depth of the target synchronizer; legal range 2..4.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 target  input  1  monitored signal, asynchronous to clk.
REQ-007 arm  input  1  arm request, synchronous to clk, level-sampled each clock.
REQ-008 trigger  output  1  registered one-shot pulse, TRIG_CYCLES cycles wide.

Function
REQ-009 target SHALL pass through a SYNC_STAGES-deep flop chain; a further flop holds the previous synchronized value (prev).
REQ-010 Edge detect SHALL be combinational from sync output and prev: rising = sync & ~prev, falling = ~sync & prev; RISING_EDGE selects which one is used.
REQ-011 FSM states: IDLE, ARMED, FIRING.
REQ-012 IDLE: arm=1 at a clock edge -> ARMED on that edge; otherwise stay.
REQ-013 ARMED: selected edge detected at a clock edge -> FIRING, trigger=1, counter loaded with TRIG_CYCLES-1, all on that edge.
REQ-014 ARMED with no edge: stay ARMED indefinitely; arm=1 has no further effect.
REQ-015 An edge detected at the same clock edge that arm is first sampled SHALL NOT fire; only the ARMED state register enables firing.
REQ-016 FIRING: trigger stays 1; each clock with counter=0 -> IDLE, trigger=0; otherwise decrement counter.
REQ-017 trigger SHALL be high for exactly TRIG_CYCLES consecutive cycles per firing.
REQ-018 Detector is one-shot: after FIRING it SHALL return to IDLE (disarmed); a new arm is required for the next firing.
REQ-019 Edges and arm during FIRING SHALL be ignored; an arm during FIRING is not remembered.
REQ-020 Non-selected edge polarity SHALL never fire or change state.
REQ-021 Latency: if target's new level is first captured at clock edge k while ARMED, trigger SHALL rise at edge k+SYNC_STAGES.
REQ-022 Target pulses shorter than one clk period need not be detected; pulses of at least 2 periods SHALL be detected.
REQ-023 Counter width SHALL be $clog2(TRIG_CYCLES+1); no wrap beyond TRIG_CYCLES-1.

Reset
REQ-024 With rst=1 at a clock edge: state IDLE, trigger 0, counter 0, all synchronizer and prev flops 0.
REQ-025 rst SHALL override arm and edge detection in the same cycle; reset mid-FIRING ends the pulse on that edge.
REQ-026 Within SYNC_STAGES+1 cycles after reset release a spurious "rising" edge may be detected if target=1; it SHALL NOT fire, since the FSM is IDLE until armed.

Structure
REQ-027 State enum (IDLE/ARMED/FIRING) SHALL live in shared package detect_edge_pkg.
REQ-028 Synchronizer SHALL be sub-module sync_chain (parameter STAGES, ports clk, rst, d, q).
REQ-029 No latches; trigger driven directly by a flop.

Verification
REQ-030 Verification uses clk period 2 ns, SYNC_STAGES=2, target idle 1, and three instances.
REQ-031 Rising-edge one-shot: TRIG_CYCLES=1, RISING_EDGE=1, one-cycle arm pulse, then target 1->0->1 (0 for 1 cycle) -> exactly one 1-cycle trigger, rising 2 edges after the 0->1 is captured; no trigger on the 1->0.
REQ-032 Wide pulse: TRIG_CYCLES=3 with the same stimulus -> trigger high exactly 3 cycles, then 0, FSM IDLE.
REQ-033 Falling-edge: RISING_EDGE=0, arm, then target 1->0 -> one 1-cycle trigger 2 edges after capture; the following 0->1 does nothing.
REQ-034 One-shot/unarmed: a second target pulse without re-arm -> trigger stays 0 on all instances; re-arm all, then target 1->0->1->0 -> each instance fires exactly once.
REQ-035 Reset/simultaneity: assert rst during FIRING -> trigger 0 on the next edge; an arm pulse coincident with a target edge -> no firing.
